sym_mapper: RTL and testbench

- Parametrised bit-serial constellation mapper; successor to the fixed 2-bit QPSK modulator.
- Collects serial bits, maps them to BPSK, QPSK or 16-QAM (runtime-selectable), and emits signed I/Q samples of width W.
- Uses a full valid/ready handshake on both sides.
- Sits between the scrambler/bit source and the pulse-shaping filter in the TX path.

---
 rtl/sym_map_pkg.sv | 22 ++
 rtl/sym_map_lut.sv | 50 +++++
 rtl/sym_mapper.sv | 109 ++++++++++
 tb/tb_sym_mapper.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sym_map_pkg.sv
// Shared types and helpers for the bit-serial constellation mapper.
// Mode encoding matches the i_mode port; reserved mode behaves as QPSK.
package sym_map_pkg;

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_QAM16 = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    localparam int MAX_BPS = 4;

    function automatic logic [2:0] bits_per_sym(input mode_e mode);
        case (mode)
            MODE_BPSK:  return 3'd1;
            MODE_QAM16: return 3'd4;
            default:    return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/sym_map_lut.sv
// Symbol-to-I/Q lookup for BPSK / QPSK / Gray-coded 16-QAM; bit 0 maps positive.
// Latency: combinational.
// Backpressure: none, pure function of mode and symbol.
module sym_map_lut
    import sym_map_pkg::*;
#(
    parameter int W         = 12,
    parameter int AMPL_BPSK = 2047,
    parameter int AMPL_QPSK = 1447,
    parameter int QAM_L1    = 647,
    parameter int QAM_L3    = 1941
) (
    input  mode_e                mode,
    input  logic [MAX_BPS-1:0]   sym,
    output logic signed [W-1:0]  sample_i,
    output logic signed [W-1:0]  sample_q
);

    localparam logic signed [W-1:0] LVL_BPSK = W'(AMPL_BPSK);
    localparam logic signed [W-1:0] LVL_QPSK = W'(AMPL_QPSK);
    localparam logic signed [W-1:0] LVL_L1   = W'(QAM_L1);
    localparam logic signed [W-1:0] LVL_L3   = W'(QAM_L3);

    // Per-axis Gray: MSB is the sign, LSB picks inner (1) or outer (0) level
    function automatic logic signed [W-1:0] qam_axis(input logic [1:0] b);
        logic signed [W-1:0] mag;
        mag = b[0] ? LVL_L1 : LVL_L3;
        return b[1] ? -mag : mag;
    endfunction

    always_comb begin
        sample_i = '0;
        sample_q = '0;
        case (mode)
            MODE_BPSK: begin
                sample_i = sym[0] ? -LVL_BPSK : LVL_BPSK;
                sample_q = '0;
            end
            MODE_QAM16: begin
                sample_i = qam_axis(sym[3:2]);
                sample_q = qam_axis(sym[1:0]);
            end
            default: begin
                sample_i = sym[1] ? -LVL_QPSK : LVL_QPSK;
                sample_q = sym[0] ? -LVL_QPSK : LVL_QPSK;
            end
        endcase
    end

endmodule

// File: rtl/sym_mapper.sv
// Bit-serial constellation mapper; optional stats via SYM_MAPPER_STATS_EN.
// Latency: sample valid one cycle after the symbol's last bit; 1 bit/cycle sustained.
// Backpressure: o_ready drops while a sample is held unconsumed; output holds stable.
module sym_mapper
    import sym_map_pkg::*;
#(
    parameter int W         = 12,
    parameter int AMPL_BPSK = 2047,
    parameter int AMPL_QPSK = 1447,
    parameter int QAM_L1    = 647,
    parameter int QAM_L3    = 1941
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          i_mode,
    input  logic                i_bit,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_out_ready,
    output logic                o_valid,
    output logic signed [W-1:0] o_I,
    output logic signed [W-1:0] o_Q
`ifdef SYM_MAPPER_STATS_EN
    ,
    output logic [31:0]         o_sym_count,
    output logic                o_mode_err
`endif
);

    if (AMPL_BPSK >= 2**(W-1) || AMPL_QPSK >= 2**(W-1) ||
        QAM_L1 >= 2**(W-1) || QAM_L3 >= 2**(W-1)) begin : g_ampl_range_err
        $error("sym_mapper: amplitude parameter does not fit in signed W bits");
    end

    logic [2:0]          cnt;
    logic [MAX_BPS-2:0]  sreg;
    mode_e               mode_q;
    mode_e               cur_mode;
    logic [MAX_BPS-1:0]  sym_next;
    logic                accept;
    logic                consume;
    logic                last;
    logic signed [W-1:0] lut_i;
    logic signed [W-1:0] lut_q;

    assign o_ready  = !rst && !(o_valid && !i_out_ready);
    assign accept   = i_valid && o_ready;
    assign consume  = o_valid && i_out_ready;

    // Mode comes straight from the port on a symbol's first bit, else the latched copy
    assign cur_mode = (cnt == 3'd0) ? mode_e'(i_mode) : mode_q;
    assign sym_next = (cnt == 3'd0) ? {{(MAX_BPS-1){1'b0}}, i_bit} : {sreg, i_bit};
    assign last     = accept && ((cnt + 3'd1) == bits_per_sym(cur_mode));

    sym_map_lut #(
        .W         (W),
        .AMPL_BPSK (AMPL_BPSK),
        .AMPL_QPSK (AMPL_QPSK),
        .QAM_L1    (QAM_L1),
        .QAM_L3    (QAM_L3)
    ) u_lut (
        .mode     (cur_mode),
        .sym      (sym_next),
        .sample_i (lut_i),
        .sample_q (lut_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            sreg    <= '0;
            mode_q  <= MODE_QPSK;
            o_valid <= 1'b0;
            o_I     <= '0;
            o_Q     <= '0;
        end else begin
            if (accept) begin
                if (cnt == 3'd0)
                    mode_q <= cur_mode;
                if (last) begin
                    cnt     <= '0;
                    o_valid <= 1'b1;
                    o_I     <= lut_i;
                    o_Q     <= lut_q;
                end else begin
                    cnt  <= cnt + 3'd1;
                    sreg <= sym_next[MAX_BPS-2:0];
                end
            end
            if (consume && !last)
                o_valid <= 1'b0;
        end
    end

`ifdef SYM_MAPPER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_sym_count <= '0;
            o_mode_err  <= 1'b0;
        end else begin
            if (consume)
                o_sym_count <= o_sym_count + 32'd1;
            if (accept && cnt == 3'd0 && mode_e'(i_mode) == MODE_RSVD)
                o_mode_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sym_mapper.sv
// Self-checking bench for sym_mapper: table-driven symbols plus stall/mode/reset sequences.
module tb_sym_mapper;

    localparam int W = 12;

    logic                clk = 1'b0;
    logic                rst;
    logic [1:0]          i_mode;
    logic                i_bit;
    logic                i_valid;
    logic                o_ready;
    logic                i_out_ready;
    logic                o_valid;
    logic signed [W-1:0] o_I;
    logic signed [W-1:0] o_Q;
`ifdef SYM_MAPPER_STATS_EN
    logic [31:0]         o_sym_count;
    logic                o_mode_err;
`endif

    sym_mapper #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_mode      (i_mode),
        .i_bit       (i_bit),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_out_ready (i_out_ready),
        .o_valid     (o_valid),
        .o_I         (o_I),
        .o_Q         (o_Q)
`ifdef SYM_MAPPER_STATS_EN
        ,
        .o_sym_count (o_sym_count),
        .o_mode_err  (o_mode_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int         nb;
        logic [3:0] bits;
        int         ei;
        int         eq;
    } vec_t;

    typedef struct {
        int i;
        int q;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard side: every consumed sample must match the oldest expected one
    always @(negedge clk) begin
        if (rst !== 1'b1 && o_valid === 1'b1 && i_out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_sample", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sample_I", o_I, e.i);
                check("sample_Q", o_Q, e.q);
            end
        end
    end

    // Drive one bit and hold it until accepted; returns just after the accepting edge
    task automatic send_bit(input logic b, input logic [1:0] m, input bit last,
                            input int ei, input int eq);
        int guard;
        i_mode  = m;
        i_bit   = b;
        i_valid = 1'b1;
        guard   = 0;
        #1;
        while (o_ready !== 1'b1) begin
            @(posedge clk); #2;
            guard++;
            if (guard > 50) begin
                check("ready_timeout", 0, 1);
                return;
            end
        end
        if (last) begin
            exp_t e;
            e.i = ei;
            e.q = eq;
            sb.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic send_symbol(input logic [1:0] m, input int nb, input logic [3:0] bits,
                               input int ei, input int eq, input int switch_mode);
        logic [1:0] cur;
        cur = m;
        for (int k = nb - 1; k >= 0; k--) begin
            if (switch_mode >= 0 && k == nb - 3)
                cur = 2'(switch_mode);
            send_bit(bits[k], cur, (k == 0), ei, eq);
        end
        check("latency_valid", o_valid, 1);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb.size() != 0 || o_valid === 1'b1) && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_empty", sb.size(), 0);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{2'd1, 2, 4'b0001,  1447, -1447};
        tbl[1] = '{2'd1, 2, 4'b0010, -1447,  1447};
        tbl[2] = '{2'd0, 1, 4'b0001, -2047,     0};
        tbl[3] = '{2'd0, 1, 4'b0000,  2047,     0};
        tbl[4] = '{2'd2, 4, 4'b1101,  -647,   647};
        tbl[5] = '{2'd2, 4, 4'b0010,  1941, -1941};
        tbl[6] = '{2'd2, 4, 4'b0111,   647,  -647};
        tbl[7] = '{2'd2, 4, 4'b1000, -1941,  1941};
        tbl[8] = '{2'd1, 2, 4'b0000,  1447,  1447};
        tbl[9] = '{2'd3, 2, 4'b0010, -1447,  1447};

        rst         = 1'b1;
        i_mode      = 2'd0;
        i_bit       = 1'b1;
        i_valid     = 1'b1;
        i_out_ready = 1'b1;

        // Reset holds everything quiet even with bits offered
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("rst_valid", o_valid, 0);
            check("rst_I", o_I, 0);
            check("rst_Q", o_Q, 0);
            check("rst_ready", o_ready, 0);
        end
        rst = 1'b0;

        // Back-to-back table stream with the sink always ready
        for (int v = 0; v < 10; v++)
            send_symbol(tbl[v].mode, tbl[v].nb, tbl[v].bits, tbl[v].ei, tbl[v].eq, -1);
        i_valid = 1'b0;
        @(posedge clk); #1;
        check("valid_drop", o_valid, 0);
        check("hold_I_after_consume", o_I, -1447);
        check("hold_Q_after_consume", o_Q, 1447);
`ifdef SYM_MAPPER_STATS_EN
        check("mode_err_set", o_mode_err, 1);
`endif

        // Backpressure: held sample, next bit pending, then release
        i_out_ready = 1'b0;
        send_symbol(2'd1, 2, 4'b0000, 1447, 1447, -1);
        i_mode  = 2'd1;
        i_bit   = 1'b1;
        i_valid = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            check("stall_ready", o_ready, 0);
            check("stall_valid", o_valid, 1);
            check("stall_I", o_I, 1447);
            check("stall_Q", o_Q, 1447);
            @(posedge clk); #2;
        end
        @(negedge clk);
        @(posedge clk); #1;
        i_out_ready = 1'b1;
        send_symbol(2'd1, 2, 4'b0011, -1447, -1447, -1);

        // Mode switched to BPSK after the second bit stays 16-QAM
        send_symbol(2'd2, 4, 4'b0111, 647, -647, 0);
        i_valid = 1'b0;
        drain();

        // Ten BPSK symbols, then a reset in the middle of a 16-QAM symbol
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int s = 0; s < 10; s++)
            send_symbol(2'd0, 1, 4'(s & 1), (s & 1) ? -2047 : 2047, 0, -1);
        i_valid = 1'b0;
        @(posedge clk); #1;
`ifdef SYM_MAPPER_STATS_EN
        check("sym_count_10", o_sym_count, 10);
`endif
        send_bit(1'b1, 2'd2, 1'b0, 0, 0);
        send_bit(1'b1, 2'd2, 1'b0, 0, 0);
        i_valid = 1'b0;
        rst     = 1'b1;
        @(posedge clk); #1;
        check("midrst_valid", o_valid, 0);
        check("midrst_I", o_I, 0);
`ifdef SYM_MAPPER_STATS_EN
        check("sym_count_cleared", o_sym_count, 0);
        check("mode_err_cleared", o_mode_err, 0);
`endif
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check("partial_no_output", o_valid, 0);
        end
        send_symbol(2'd2, 4, 4'b0010, 1941, -1941, -1);
        i_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
